// File: rtl/arcino_pic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arcino_pic_pkg : shared types and widths for the interrupt ctrl |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package arcino_pic_pkg;

   localparam int IRQ_ID_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2
   } irq_ctrl_e;

endpackage : arcino_pic_pkg
`default_nettype wire

// File: rtl/arcino_pic_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arcino_pic_if : interrupt lines, CSR view and controller hshake |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface arcino_pic_if #(
   parameter int NUM_IRQ = 32
);
   logic [NUM_IRQ-1:0]                   irq_i;
   logic [NUM_IRQ-1:0]                   irq_en_i;
   logic [NUM_IRQ-1:0]                   irq_edge_i;
   logic                                 m_IE_i;
   logic                                 irq_req_ctrl_o;
   logic [arcino_pic_pkg::IRQ_ID_W-1:0]  irq_id_ctrl_o;
   logic                                 ctrl_ack_i;
   logic                                 ctrl_kill_i;
   logic [NUM_IRQ-1:0]                   irq_pending_o;

   modport slave (
      input  irq_i, irq_en_i, irq_edge_i, m_IE_i, ctrl_ack_i, ctrl_kill_i,
      output irq_req_ctrl_o, irq_id_ctrl_o, irq_pending_o
   );

   modport master (
      output irq_i, irq_en_i, irq_edge_i, m_IE_i, ctrl_ack_i, ctrl_kill_i,
      input  irq_req_ctrl_o, irq_id_ctrl_o, irq_pending_o
   );
endinterface : arcino_pic_if
`default_nettype wire

// File: rtl/arcino_pic_prio_enc.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arcino_prio_enc : combinational fixed-priority encoder,         |
// |                   lowest set index wins                         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module arcino_prio_enc
   import arcino_pic_pkg::*;
#(
   parameter int N = 32
) (
   input  wire logic [N-1:0]        i_vec,
   output logic                     valid_o,
   output logic [IRQ_ID_W-1:0]      id_o
);

   always_comb begin
      valid_o = 1'b0;
      id_o    = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            valid_o = 1'b1;
            id_o    = IRQ_ID_W'(i);
         end
      end
   end

endmodule : arcino_prio_enc
`default_nettype wire

// File: rtl/arcino_pic.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arcino_pic : multi-source PIC, level/edge sources, fixed prio,  |
// |              single request + id toward the pipeline controller |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module arcino_pic
   import arcino_pic_pkg::*;
#(
   parameter int NUM_IRQ = 32
) (
   input  wire logic        clk_i,
   input  wire logic        rst_i,
   arcino_pic_if.slave      bus
);

   logic [NUM_IRQ-1:0]   r_irq_q;
   logic [NUM_IRQ-1:0]   r_edge_pend;
   logic [NUM_IRQ-1:0]   w_edge_pend_d;
   logic [NUM_IRQ-1:0]   w_rise;
   logic [NUM_IRQ-1:0]   w_pend;
   logic [NUM_IRQ-1:0]   w_elig;
   irq_ctrl_e            r_state;
   irq_ctrl_e            w_state_d;
   logic [IRQ_ID_W-1:0]  r_id_q;
   logic [IRQ_ID_W-1:0]  w_id_d;
   logic [IRQ_ID_W-1:0]  w_win_id;
   logic                 w_win_vld;
   logic                 w_ack_clr;

   assign w_rise = bus.irq_i & ~r_irq_q;
   assign w_pend = (bus.irq_edge_i & (r_edge_pend | w_rise)) |
                   (~bus.irq_edge_i & bus.irq_i);
   assign w_elig = w_pend & bus.irq_en_i;

   arcino_prio_enc #(.N(NUM_IRQ)) u_prio (
      .i_vec   (w_elig),
      .valid_o (w_win_vld),
      .id_o    (w_win_id)
   );

   // A fresh rise beats a same-cycle ack clear so the new event survives.
   always_comb begin
      w_edge_pend_d = '0;
      for (int n = 0; n < NUM_IRQ; n++) begin
         w_edge_pend_d[n] = bus.irq_edge_i[n] &
                            (w_rise[n] |
                             (r_edge_pend[n] & ~(w_ack_clr && (r_id_q == IRQ_ID_W'(n)))));
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_id_d    = r_id_q;
      w_ack_clr = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.m_IE_i && w_win_vld) begin
               w_state_d = PENDING;
               w_id_d    = w_win_id;
            end
         end
         PENDING: begin
            if (bus.ctrl_ack_i) begin
               w_state_d = DONE;
               w_ack_clr = 1'b1;
            end else if (bus.ctrl_kill_i) begin
               w_state_d = IDLE;
            end
         end
         DONE:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_irq_q     <= '0;
         r_edge_pend <= '0;
         r_id_q      <= '0;
      end else begin
         r_state     <= w_state_d;
         r_irq_q     <= bus.irq_i;
         r_edge_pend <= w_edge_pend_d;
         r_id_q      <= w_id_d;
      end
   end

   assign bus.irq_req_ctrl_o = (r_state == PENDING);
   assign bus.irq_id_ctrl_o  = r_id_q;
   assign bus.irq_pending_o  = w_pend;

endmodule : arcino_pic
`default_nettype wire
